// File: rtl/median_frame_ctrl.sv
// median_frame_ctrl: frame sequencer for the 3x3 median filter. It clears the
// filter, streams one WIDTH x HEIGHT frame from the source BRAM into the filter,
// appends one zero flush row, and writes the N filtered pixels to the destination
// BRAM in raster order.
// Ports: clk/rst (async, active-high); start/pause/busy/done control;
//   flt_clr registered filter clear; src_rd_en/src_addr/src_rd_data source read
//   (1-cycle latency); flt_pixel_valid/flt_pixel_in filter drive;
//   flt_out_valid/flt_out filter result; dst_wr_en/dst_addr/dst_wr_data dest write.
module median_frame_ctrl #(
  parameter int WIDTH  = 430,
  parameter int HEIGHT = 320,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  output logic              busy,
  output logic              done,
  output logic              flt_clr,
  output logic              src_rd_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [7:0]        src_rd_data,
  output logic              flt_pixel_valid,
  output logic [7:0]        flt_pixel_in,
  input  logic              flt_out_valid,
  input  logic [7:0]        flt_out,
  output logic              dst_wr_en,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [7:0]        dst_wr_data
);

  localparam int N    = WIDTH * HEIGHT;
  localparam int FL_W = $clog2(WIDTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [FL_W-1:0]   LAST_COL  = FL_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] rd_cnt;
  logic [FL_W-1:0]   fl_cnt;
  logic [ADDR_W-1:0] wr_cnt;
  logic              iss_v;
  logic              iss_zero;
  logic              issue;
  logic              wr_fire;

  // Writes are accepted in every active state after the clear cycle; the
  // filter output is registered, so the final write lands while in DRAIN.
  assign wr_fire = flt_out_valid && (state != S_IDLE) && (state != S_CLEAR);

  always_comb begin
    state_n = state;
    issue   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_n = S_CLEAR;
      end
      S_CLEAR: begin
        state_n = S_FEED;
      end
      S_FEED: begin
        if (!pause) begin
          issue = 1'b1;
          if (rd_cnt == LAST_ADDR) state_n = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (!pause) begin
          issue = 1'b1;
          if (fl_cnt == LAST_COL) state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (wr_fire && (wr_cnt == LAST_ADDR)) state_n = S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      flt_clr <= 1'b0;
    end else begin
      state   <= state_n;
      // Registered so the filter sees a clean, glitch-free clear for the
      // whole CLEAR cycle.
      flt_clr <= (state_n == S_CLEAR);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt   <= '0;
      fl_cnt   <= '0;
      wr_cnt   <= '0;
      iss_v    <= 1'b0;
      iss_zero <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      rd_cnt   <= '0;
      fl_cnt   <= '0;
      wr_cnt   <= '0;
      iss_v    <= 1'b0;
      iss_zero <= 1'b0;
    end else begin
      // Issue stage lines up with the 1-cycle source read latency.
      iss_v    <= issue;
      iss_zero <= issue && (state == S_FLUSH);
      if (issue && (state == S_FEED))  rd_cnt <= rd_cnt + 1'b1;
      if (issue && (state == S_FLUSH)) fl_cnt <= fl_cnt + 1'b1;
      if (wr_fire)                     wr_cnt <= wr_cnt + 1'b1;
    end
  end

  assign busy            = (state != S_IDLE);
  assign done            = (state == S_DONE);
  assign src_rd_en       = issue && (state == S_FEED);
  assign src_addr        = src_rd_en ? rd_cnt : '0;
  assign flt_pixel_valid = iss_v;
  assign flt_pixel_in    = (iss_v && !iss_zero) ? src_rd_data : 8'd0;
  assign dst_wr_en       = wr_fire;
  assign dst_addr        = wr_cnt;
  // Gated so the write bus is quiet whenever no write is in progress.
  assign dst_wr_data     = wr_fire ? flt_out : 8'd0;

endmodule

// File: tb/tb_median_frame_ctrl.sv
// Bench for median_frame_ctrl with a small frame, a source memory model and a
// stand-in filter (vertical 3-tap median, first row passed through, one row of
// latency plus a registered output). A scoreboard checks every dst write.
module tb_median_frame_ctrl;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 8;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          busy, done, flt_clr, src_rd_en;
  logic [AW-1:0] src_addr;
  logic [7:0]    src_rd_data;
  logic          flt_pixel_valid;
  logic [7:0]    flt_pixel_in;
  logic          flt_out_valid;
  logic [7:0]    flt_out;
  logic          dst_wr_en;
  logic [AW-1:0] dst_addr;
  logic [7:0]    dst_wr_data;

  median_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .busy(busy), .done(done),
    .flt_clr(flt_clr), .src_rd_en(src_rd_en), .src_addr(src_addr),
    .src_rd_data(src_rd_data), .flt_pixel_valid(flt_pixel_valid),
    .flt_pixel_in(flt_pixel_in), .flt_out_valid(flt_out_valid), .flt_out(flt_out),
    .dst_wr_en(dst_wr_en), .dst_addr(dst_addr), .dst_wr_data(dst_wr_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int med3(input int a, input int b, input int c);
    int lo, hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    return (c < lo) ? lo : ((c > hi) ? hi : c);
  endfunction

  // Source memory, 1-cycle read latency.
  logic [7:0] src_mem [0:N-1];
  always @(posedge clk) begin
    if (src_rd_en) src_rd_data <= src_mem[src_addr];
  end

  // Stand-in filter: output for centre pixel c appears one clock after the
  // pixel one row below it is presented.
  logic [7:0] fin [0:(H+1)*W-1];
  int fcnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt          <= 0;
      flt_out_valid <= 1'b0;
      flt_out       <= 8'd0;
    end else if (flt_clr) begin
      fcnt          <= 0;
      flt_out_valid <= 1'b0;
      flt_out       <= 8'd0;
    end else begin
      flt_out_valid <= 1'b0;
      if (flt_pixel_valid && fcnt < (H + 1) * W) begin
        fin[fcnt] <= flt_pixel_in;
        fcnt      <= fcnt + 1;
        if (fcnt >= W) begin
          flt_out_valid <= 1'b1;
          if (fcnt < 2 * W) flt_out <= fin[fcnt-W];
          else flt_out <= 8'(med3(fin[fcnt-2*W], fin[fcnt-W], flt_pixel_in));
        end
      end
    end
  end

  // Scoreboard: expected {addr, data} pairs in write order.
  int   exp_q [$];
  logic [7:0] dst_mem [0:N-1];
  int   wr_seen  = 0;
  int   clr_seen = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (flt_clr) clr_seen++;
      if (flt_clr && flt_pixel_valid) check("clr_vs_valid", 1, 0);
      if (dst_wr_en) begin
        wr_seen++;
        if (int'(dst_addr) < N) dst_mem[dst_addr] = dst_wr_data;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          int e;
          e = exp_q.pop_front();
          check("dst_addr", int'(dst_addr), e >> 8);
          check("dst_data", int'(dst_wr_data), e & 255);
        end
      end
    end
  end

  // Reference: raster-order results of the stand-in filter over the frame
  // extended by one zero row.
  task automatic push_expected();
    for (int k = 0; k < N; k++) begin
      int r, v, below;
      r = k / W;
      if (r == 0) v = src_mem[k];
      else begin
        below = (r == H - 1) ? 0 : int'(src_mem[k+W]);
        v = med3(src_mem[k-W], src_mem[k], below);
      end
      exp_q.push_back((k << 8) | v);
    end
  endtask

  task automatic run_frame(input bit paused, input bit dup_start);
    int cyc, clr0, wr0;
    bit got;
    push_expected();
    clr0 = clr_seen;
    wr0  = wr_seen;
    got  = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    cyc = 1;
    for (int g = 0; g < 300; g++) begin
      @(negedge clk);
      start = dup_start && (cyc == 8);
      pause = paused && (cyc >= 5) && (cyc < 10);
      #1;
      if (pause) check("no_read_in_pause", int'(src_rd_en), 0);
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      cyc++;
    end
    start = 1'b0;
    pause = 1'b0;
    if (!got) check("done_timeout", 0, 1);
    check("start_to_done", cyc, paused ? 25 : 20);
    check("clr_pulses", clr_seen - clr0, 1);
    @(negedge clk);
    check("write_count", wr_seen - wr0, N);
    check("queue_drained", exp_q.size(), 0);
    check("done_one_cycle", int'(done), 0);
    check("idle_after", int'(busy), 0);
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, int'({busy, done, flt_clr, src_rd_en, src_addr, flt_pixel_valid,
                      flt_pixel_in, dst_wr_en, dst_addr, dst_wr_data}), 0);
  endtask

  task automatic fill_random();
    for (int k = 0; k < N; k++) src_mem[k] = 8'($urandom_range(0, 255));
  endtask

  logic [7:0] saved [0:N-1];
  int diffs;

  initial begin
    for (int k = 0; k < N; k++) src_mem[k] = 8'd10;
    src_mem[5] = 8'd255;

    // Reset behaviour, including a reset taken while idle.
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset_outputs");
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 check_outputs_zero("idle_reset_outputs");
    check("idle_reset_busy", int'(busy), 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("quiet_after_reset", int'({busy, flt_clr, src_rd_en, flt_pixel_valid, dst_wr_en}), 0);
    end

    // Reference frame, then the same frame with a 5-cycle pause mid-FEED.
    run_frame(1'b0, 1'b0);
    check("dst5_median", int'(dst_mem[5]), 10);
    for (int k = 0; k < N; k++) saved[k] = dst_mem[k];
    for (int k = 0; k < N; k++) dst_mem[k] = 8'hxx;
    run_frame(1'b1, 1'b0);
    diffs = 0;
    for (int k = 0; k < N; k++) if (dst_mem[k] !== saved[k]) diffs++;
    check("paused_same_result", diffs, 0);

    // Back-to-back random frames.
    for (int f = 0; f < 3; f++) begin
      fill_random();
      run_frame(1'b0, 1'b0);
    end

    // Start pulsed while busy is ignored.
    fill_random();
    run_frame(1'b0, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("no_second_frame", int'(busy), 0);
    end

    // Reset mid-FEED, then a clean frame.
    fill_random();
    push_expected();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (5) @(negedge clk);
    check("in_feed_before_reset", int'(src_rd_en), 1);
    rst = 1'b1;
    #1 check_outputs_zero("midframe_reset_outputs");
    exp_q.delete();
    @(negedge clk) rst = 1'b0;
    fill_random();
    run_frame(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
